// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display scanner: segment patterns and parameter defaults.
// Patterns are active-low {g,f,e,d,c,b,a}. No logic, no latency, no flow control.
package display_pkg;

  localparam int DIGITS_DEF      = 4;
  localparam int SLOT_CYCLES_DEF = 5000;
  localparam int BRIGHT_W_DEF    = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_decode.sv
// Hex nibble to active-low segments {dp,g,f,e,d,c,b,a}; blank forces a-g off, dp still honoured.
// Purely combinational, zero latency, no backpressure.
module seg_decode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {~dp, (blank ? SEG_BLANK : SEG_HEX[nibble])};

endmodule

// File: rtl/display_scan.sv
// Multiplexed 7-segment scanner with frame-synchronous value update and PWM brightness; an/sseg registered
// (1 cycle after index/sub-phase). No backpressure: last load wins. DISPLAY_SCAN_LZB_EN enables zero blanking.
module display_scan
  import display_pkg::*;
#(
  parameter int DIGITS      = DIGITS_DEF,
  parameter int SLOT_CYCLES = SLOT_CYCLES_DEF,
  parameter int BRIGHT_W    = BRIGHT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic                  lz_blank,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            sseg,
  output logic                  frame_done
);

  localparam int CNT_W      = $clog2(SLOT_CYCLES);
  localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SUB_CYCLES = SLOT_CYCLES >> BRIGHT_W;
  localparam int SUB_W      = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;
  localparam logic [BRIGHT_W-1:0] BRIGHT_MAX = '1;

  logic [CNT_W-1:0]    pre_cnt;
  logic [SUB_W-1:0]    sub_cnt;
  logic [BRIGHT_W-1:0] sub_phase;
  logic [IDX_W-1:0]    idx;
  logic                slot_tick;
  logic                frame_tick;
  logic                pending;
  logic [4*DIGITS-1:0] stage_val;
  logic [4*DIGITS-1:0] disp_val;
  logic [DIGITS-1:0]   stage_dp;
  logic [DIGITS-1:0]   disp_dp;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic                lit;
  logic [7:0]          cur_seg;

  assign slot_tick  = (pre_cnt == CNT_W'(SLOT_CYCLES - 1));
  assign frame_tick = slot_tick && (idx == IDX_W'(DIGITS - 1));

  // Sub-phase saturates so a slot length that is not an exact multiple still ends dark-safe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_cnt   <= '0;
      sub_cnt   <= '0;
      sub_phase <= '0;
      idx       <= '0;
    end else if (slot_tick) begin
      pre_cnt   <= '0;
      sub_cnt   <= '0;
      sub_phase <= '0;
      idx       <= frame_tick ? '0 : idx + 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
      if (sub_cnt == SUB_W'(SUB_CYCLES - 1)) begin
        sub_cnt <= '0;
        if (sub_phase != BRIGHT_MAX) sub_phase <= sub_phase + 1'b1;
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end
    end
  end

  // The boundary copy uses the old staging contents, so a load on that same cycle waits a frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending    <= 1'b0;
      stage_val  <= '0;
      stage_dp   <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_tick;
      if (frame_tick && pending) begin
        disp_val <= stage_val;
        disp_dp  <= stage_dp;
      end
      if (load) begin
        stage_val <= value;
        stage_dp  <= dp;
        pending   <= 1'b1;
      end else if (frame_tick) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib = disp_val[4*i +: 4];
        cur_dp  = disp_dp[i];
      end
    end
  end

`ifdef DISPLAY_SCAN_LZB_EN
  logic [DIGITS-1:0] lz_mask;

  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (disp_val[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run;
    end
  end

  assign cur_blank = lz_blank && lz_mask[idx];
`else
  assign cur_blank = lz_blank & 1'b0;
`endif

  assign lit = (brightness == BRIGHT_MAX) || (sub_phase < brightness);

  seg_decode u_seg_decode (
    .nibble (cur_nib),
    .blank  (cur_blank),
    .dp     (cur_dp),
    .seg    (cur_seg)
  );

  // Anodes forced off on the slot's last cycle so the index change never overlaps a lit digit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      an   <= '1;
      sseg <= 8'hFF;
    end else begin
      an   <= (lit && !slot_tick) ? ~(DIGITS'(1) << idx) : '1;
      sseg <= cur_seg;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan at DIGITS=4, SLOT_CYCLES=16, BRIGHT_W=2.
// Expected segment bytes and on-times are hand-computed constants.
module tb_display_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic [1:0]  brightness;
  logic        lz_blank;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  display_scan #(
    .DIGITS      (4),
    .SLOT_CYCLES (16),
    .BRIGHT_W    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp         (dp),
    .load       (load),
    .brightness (brightness),
    .lz_blank   (lz_blank),
    .an         (an),
    .sseg       (sseg),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_frame(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = frame_done;
    end
    chk({tag, "_frame_seen"}, {31'd0, seen}, 32'd1);
  endtask

  // Entered on the sample where frame_done is high; leaves on the next frame's equivalent sample.
  // seg_exp holds digit0 in [7:0] up to digit3 in [31:24].
  task automatic scan_frame(input string tag, input logic [31:0] seg_exp, input int low_exp);
    int         low [4];
    int         seg_err;
    int         other_err;
    int         s;
    logic [3:0] on_pat;
    low       = '{0, 0, 0, 0};
    seg_err   = 0;
    other_err = 0;
    chk({tag, "_guard"}, {28'd0, an}, 32'hF);
    for (int j = 1; j <= 64; j++) begin
      @(negedge clk);
      s      = (j - 1) / 16;
      on_pat = ~(4'b0001 << s);
      if (an == on_pat) begin
        low[s]++;
        if (sseg != seg_exp[8*s +: 8]) seg_err++;
      end else if (an != 4'hF) begin
        other_err++;
      end
    end
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_low%0d", tag, k), low[k], low_exp);
    chk({tag, "_seg_err"}, seg_err, 0);
    chk({tag, "_stray_an"}, other_err, 0);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    int n;
    rst        = 1'b0;
    load       = 1'b0;
    value      = '0;
    dp         = '0;
    brightness = 2'd3;
    lz_blank   = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_an%0d", i), {28'd0, an}, 32'hF);
      chk($sformatf("rst_sseg%0d", i), {24'd0, sseg}, 32'hFF);
      chk($sformatf("rst_fd%0d", i), {31'd0, frame_done}, 32'd0);
    end
    rst = 1'b1;

    pulse_load(16'h12A4, 4'b0000);
    wait_frame("f12a4");
    scan_frame("b3", 32'hF9A48899, 15);
    brightness = 2'd1;
    scan_frame("b1", 32'hF9A48899, 4);
    brightness = 2'd0;
    scan_frame("b0", 32'hF9A48899, 0);
    brightness = 2'd2;
    scan_frame("b2", 32'hF9A48899, 8);

    brightness = 2'd3;
    pulse_load(16'h1111, 4'b0000);
    repeat (5) @(negedge clk);
    pulse_load(16'h2222, 4'b0100);
    wait_frame("f2222");
    scan_frame("last_wins", 32'hA424A4A4, 15);

    lz_blank = 1'b1;
    pulse_load(16'h0030, 4'b0000);
    wait_frame("f0030");
`ifdef DISPLAY_SCAN_LZB_EN
    scan_frame("lzb", 32'hFFFFB0C0, 15);
`else
    scan_frame("lzb", 32'hC0C0B0C0, 15);
`endif

    lz_blank = 1'b0;
    pulse_load(16'hFFFF, 4'b1111);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (frame_done) begin
        n = i;
        break;
      end
    end
    chk("rst_first_frame", n, 64);
    scan_frame("rst_drop", 32'hC0C0C0C0, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter SLOT_CYCLES, default 5000: clk cycles per digit slot (multiple of 2**BRIGHT_W, >= 2**BRIGHT_W).
REQ-003 SHALL have parameter BRIGHT_W, default 4: width of brightness control.
REQ-004 SHALL have port clk  input  1: the only clock; reset is synchronous and active-low.
REQ-005 SHALL have port rst  input  1: synchronous, active-low reset, sampled on rising clk.
REQ-006 SHALL have port value  input  4*DIGITS: hex nibbles, nibble i drives digit i (digit 0 = LSD).
REQ-007 SHALL have port dp  input  DIGITS: decimal point per digit, 1 = lit.
REQ-008 SHALL have port load  input  1: one-cycle strobe requesting capture of value/dp.
REQ-009 SHALL have port brightness  input  BRIGHT_W: on-time per slot, sampled live.
REQ-010 SHALL have port lz_blank  input  1: leading-zero blanking enable.
REQ-011 SHALL have port an  output  DIGITS: anode enables, active-low.
REQ-012 SHALL have port sseg  output  8: segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-013 SHALL have port frame_done  output  1: one-cycle pulse at each frame boundary.

Function
REQ-014 Prescaler SHALL count 0..SLOT_CYCLES-1 and wrap; terminal count = slot tick.
REQ-015 Digit index SHALL advance on slot tick, 0..DIGITS-1, wrapping to 0; the wrap tick is the frame boundary.
REQ-016 load SHALL set a pending flag and latch value/dp into a staging register; a load while pending overwrites staging (last wins).
REQ-017 Staging SHALL copy to the display register only at a frame boundary with pending set, then clear pending; load on the boundary cycle itself is taken at the next boundary.
REQ-018 frame_done SHALL pulse for the cycle after each frame boundary.
REQ-019 Slot SHALL divide into 2**BRIGHT_W equal sub-phases; selected anode low while sub-phase < brightness; brightness all-ones SHALL mean on for the full slot; brightness 0 SHALL mean dark.
REQ-020 Leading-zero blanking (when compiled and lz_blank=1): zero nibbles from the MSD down to the first nonzero nibble SHALL show segments a-g off; digit 0 never blanked; dp still honoured.
REQ-021 an and sseg SHALL be registered; one cycle latency from index/sub-phase change.
REQ-022 At most one anode low at any cycle; all anodes high for the cycle an index changes (ghosting guard).

Reset
REQ-023 On rst=0 at a clk edge: prescaler 0, index 0, pending 0, staging and display registers 0, an all ones, sseg 8'hFF, frame_done 0.
REQ-024 Reset mid-frame SHALL discard any pending load.

Configuration
REQ-025 Macro DISPLAY_SCAN_LZB_EN defined: REQ-020 active; undefined: lz_blank ignored, all digits always decoded.

Structure
REQ-026 Shared package display_pkg SHALL hold segment encoding constants (16 hex patterns, blank pattern) and parameter defaults.
REQ-027 Sub-module seg_decode (nibble + blank + dp -> 8-bit active-low segments) SHALL be instantiated once on the selected digit.

Verification (DIGITS=4, SLOT_CYCLES=16, BRIGHT_W=2)
REQ-028 Reset held 3 cycles -> an=4'hF, sseg=8'hFF, frame_done=0 throughout.
REQ-029 load with value=16'h12A4, brightness=3 -> after next boundary, slots show 4,A,2,1 with an=1110,1101,1011,0111, each 15-16 cycles low.
REQ-030 brightness=1 -> anode low 4 of 16 cycles per slot; brightness=0 -> an stays 4'hF.
REQ-031 Two loads (16'h1111 then 16'h2222) within one frame -> only 2222 displayed, from next boundary; no frame shows mixed digits.
REQ-032 DISPLAY_SCAN_LZB_EN, lz_blank=1, value=16'h0030 -> digits 3,2 blank (sseg=8'hFF unless dp), digit1 shows 3, digit0 shows 0.
REQ-033 Reset asserted with pending load -> display register stays 0 after release; frame_done first pulses after 64 cycles.
